instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end for the ARM core: the producing end of the `Instr[31:0]` stream that the control decoder consumes. Holds the fetch PC and issues word reads to instruction memory over a req/ack handshake. Buffers returned words in a small FIFO and presents them downstream with valid/ready. Accepts branch redirects (taken `PCSrc` plus target) and flushes stale fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 2: FIFO entries, power of two, ≥2.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: read request.
- `imem_addr` out 32: word address; bits [1:0] always 0.
- `imem_ack` in 1: read complete; `imem_rdata` valid this cycle.
- `imem_rdata` in 32: returned instruction word.
- `instr_valid` out 1: `instr`/`instr_pc` hold a valid entry.
- `instr` out 32: instruction word to the controller/datapath.
- `instr_pc` out 32: address of `instr`.
- `instr_ready` in 1: consumer accepts the head entry this cycle.
- `redirect` in 1: taken branch / PC write (from `PCSrc`).
- `redirect_pc` in 32: new fetch address; bits [1:0] ignored and forced 0.

## Operation
- States:
  - FETCH: `imem_req`=1 while `credits` > 0.
  - WAIT: req outstanding.
  - DROP: outstanding req belongs to a flushed stream.
- Credits:
  - `credits` = DEPTH − occupancy − (req outstanding ? 1 : 0).
  - No request is issued when credits = 0; the FIFO therefore never overflows.
- Handshake:
  - A transfer occurs on any cycle with `imem_req && imem_ack`, including the cycle req rises.
  - Once raised, `imem_req` and `imem_addr` stay stable until ack.
  - At most one request is outstanding.
- On ack in FETCH/WAIT:
  - Push {`imem_rdata`, `imem_addr`}.
  - fetch_pc += 4, wrapping modulo 2^32.
  - Stay in FETCH if credits remain after the push, else idle with req low.
- Pop on `instr_valid && instr_ready`.
- Push and pop in the same cycle: occupancy unchanged.
- Redirect, taking priority over all else:
  - FIFO flushed at the clock edge; `instr_valid`=0 next cycle.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - If a req is outstanding and not acked this cycle: go to DROP, holding req/addr unchanged until ack. The acked data is discarded, then a request to the new PC issues on the following cycle.
  - If ack coincides with redirect: data discarded, no DROP; the new request starts next cycle.
  - Pop in the same cycle as redirect: the head is consumed, and the rest is flushed.
  - Redirect while in DROP: updates the target PC only and remains in DROP.
- Reset mid-transaction:
  - Everything clears immediately.
  - A pending memory ack after reset is ignored, because req is 0 in the first post-reset state.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - State FETCH, occupancy 0, fetch_pc=RESET_PC.
- First clock edge after reset deassertion: `imem_req`=1, `imem_addr`=RESET_PC.
- Ack at edge N: entry visible (`instr_valid`=1) after edge N, i.e. one-cycle registered latency. The next request is raised in the same cycle.
- Zero-wait memory (ack same cycle as req) with an always-ready consumer: sustained one instruction per cycle.
- Redirect at edge N, no outstanding req: `imem_addr`=redirect target after edge N.
- Outputs are registered/FIFO-head driven. There is no combinational path from `instr_ready` or `redirect` to `imem_req`/`imem_addr`.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum {FETCH, WAIT, DROP}.
  - `fetch_entry_t` struct {instr, pc}.
  - Localparam `WORD_BYTES`=4.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`.
  - Ports: push, pop, flush, full, empty, count, head.
  - Flush has priority over push in the same cycle.
- Top level holds the state machine, fetch_pc and credit logic.

## Test plan
- Reset, then zero-wait memory returning addr-as-data, ready=1 → `instr_pc` sequence 0,4,8,…, one per cycle, `instr`=`instr_pc`.
- ready=0, DEPTH=2 → exactly two acks accepted, then `imem_req`=0. Release ready → req reasserts the next cycle at 0x8.
- 3-cycle ack latency, redirect to 0x100 one cycle after req to 0x10 → 0x10 held until ack, data dropped, next `imem_addr`=0x100. First `instr_pc` observed =0x100.
- Redirect coincident with ack and pop → popped entry delivered, ack data discarded, next `imem_addr`=redirect_pc.
- `redirect_pc`=0x203 → `imem_addr`=0x200.
- fetch_pc=0xFFFF_FFFC → the next fetch wraps to 0x0.
- Assert reset during WAIT, with ack arriving during reset → outputs at reset values. First post-reset request is to RESET_PC, and no stale entry appears.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush beats push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: storage is reset so the head (instr/instr_pc) reads zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetch PC, credit-limited imem req/ack, output FIFO,
// branch redirect with drop of the in-flight stale fetch.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   pc_q, pc_d;

  logic          xfer, push, pop, flush, can_issue;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, occ_next;
  logic [31:0]   target;
  fetch_entry_t  fifo_din, fifo_head;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
    end
  end

  // In WAIT, addr_q equals pc_q; in DROP, addr_q holds the stale request while pc_q tracks the target.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    unique case (state_q)
      FETCH: begin
        if (redirect) pc_d = target;
        if (can_issue) begin
          req_d   = 1'b1;
          addr_d  = pc_d;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (xfer) begin
          pc_d = redirect ? target : pc_q + 32'(WORD_BYTES);
          if (can_issue) begin
            req_d  = 1'b1;
            addr_d = pc_d;
          end else begin
            req_d   = 1'b0;
            state_d = FETCH;
          end
        end else if (redirect) begin
          pc_d    = target;
          state_d = DROP;
        end
      end
      DROP: begin
        if (redirect) pc_d = target;
        if (xfer) begin
          if (can_issue) begin
            req_d   = 1'b1;
            addr_d  = pc_d;
            state_d = WAIT;
          end else begin
            req_d   = 1'b0;
            state_d = FETCH;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Credit test uses post-edge occupancy: a new request needs a free slot beyond what is queued.
  always_comb begin
    target      = align_word(redirect_pc);
    xfer        = req_q && imem_ack;
    flush       = redirect;
    pop         = !fifo_empty && instr_ready;
    push        = xfer && (state_q != DROP) && !redirect && (!fifo_full || pop);
    fifo_din    = '{instr: imem_rdata, pc: addr_q};
    occ_next    = flush ? '0 : fifo_count + CW'(push) - CW'(pop);
    can_issue   = (occ_next < CW'(DEPTH));
    imem_req    = req_q;
    imem_addr   = addr_q;
    instr_valid = !fifo_empty;
    instr       = fifo_head.instr;
    instr_pc    = fifo_head.pc;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit with an in-order PC stream model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] key;
  logic [31:0] exp_pc;
  bit          mem_busy;
  int          mem_wait;
  int          lat_fixed;
  int          lat_max;
  bit          last_ack;
  int          ack_count;
  bit          found;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ key;
  endfunction

  // Memory: each new request waits a chosen number of cycles, then acks once.
  task automatic mem_drive();
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(lat_max, 0));
      end
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = memf(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_wait--;
      end
    end else begin
      imem_ack = 1'b0;
      mem_busy = 1'b0;
    end
  endtask

  // One clock from negedge to negedge; the model advances on what the edge will see.
  task automatic tick();
    logic [31:0] p_addr;
    bit          p_req, p_ack, p_redir;
    mem_drive();
    if (instr_valid && instr_ready) begin
      check("pop_pc", instr_pc, exp_pc);
      check("pop_data", instr, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
    p_req   = imem_req;
    p_addr  = imem_addr;
    p_ack   = imem_ack;
    p_redir = redirect;
    last_ack = p_req && p_ack;
    if (last_ack) ack_count++;
    @(negedge clk);
    if (p_req && !p_ack) begin
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, p_addr);
    end
    check("addr_align", imem_addr[1:0], 0);
    if (p_redir) check("flush_valid", instr_valid, 0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    imem_ack = 1'b0;
    redirect = 1'b0;
    mem_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    exp_pc    = RESET_PC;
    ack_count = 0;
  endtask

  initial begin
    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; key = '0; lat_fixed = 0; lat_max = 0;
    mem_busy = 1'b0; mem_wait = 0; exp_pc = RESET_PC; ack_count = 0;
    repeat (2) @(negedge clk);

    // Reset values, then zero-wait addr-as-data streaming
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    reset = 1'b0;
    instr_ready = 1'b1;
    tick();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, RESET_PC);
    tick();
    check("first_valid", instr_valid, 1);
    check("first_pc", instr_pc, 0);
    check("first_instr", instr, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("stream_valid", instr_valid, 1);
      check("stream_pc", instr_pc, 32'(4 * i));
      check("stream_instr", instr, 32'(4 * i));
    end

    // Backpressure: two acks fill DEPTH=2, then req drops until a pop
    key = 32'h5A5A_0F0F;
    instr_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    check("bp_acks", ack_count, 2);
    check("bp_req_low", imem_req, 0);
    check("bp_valid", instr_valid, 1);
    check("bp_head_pc", instr_pc, 0);
    instr_ready = 1'b1;
    tick();
    check("bp_resume_req", imem_req, 1);
    check("bp_resume_addr", imem_addr, 32'h8);

    // Redirect while a 3-cycle request to 0x10 is outstanding
    lat_fixed = 3;
    do_reset();
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      tick();
      found = imem_req && (imem_addr == 32'h10);
    end
    check("t3_req10_seen", found, 1);
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("t3_hold_req", imem_req, 1);
    check("t3_hold_addr", imem_addr, 32'h10);
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      found = last_ack;
    end
    check("t3_ack_seen", found, 1);
    check("t3_next_req", imem_req, 1);
    check("t3_next_addr", imem_addr, 32'h100);
    for (int n = 0; n < 20 && !instr_valid; n++) tick();
    check("t3_first_valid", instr_valid, 1);
    check("t3_first_pc", instr_pc, 32'h100);

    // Redirect coincident with ack and pop
    lat_fixed = 0;
    key = 32'h1234_5678;
    do_reset();
    repeat (6) tick();
    check("t4_pre_valid", instr_valid, 1);
    check("t4_pre_req", imem_req, 1);
    redirect = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    check("t4_addr", imem_addr, 32'h400);
    check("t4_req", imem_req, 1);
    tick();
    check("t4_first_valid", instr_valid, 1);
    check("t4_first_pc", instr_pc, 32'h400);

    // Unaligned redirect with no request outstanding (FIFO full, req idle)
    instr_ready = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      found = !imem_req;
    end
    check("t5_idle", found, 1);
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    check("t5_addr", imem_addr, 32'h200);
    check("t5_req", imem_req, 1);
    instr_ready = 1'b1;
    tick();
    check("t5_valid", instr_valid, 1);
    check("t5_pc", instr_pc, 32'h200);

    // PC wrap past 0xFFFF_FFFC
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF4;
    tick();
    redirect = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      found = instr_valid && (instr_pc == 32'hFFFF_FFFC);
    end
    check("t6_top_seen", found, 1);
    tick();
    check("t6_wrap_valid", instr_valid, 1);
    check("t6_wrap_pc", instr_pc, 32'h0);

    // Reset during WAIT with the ack arriving during and just after reset
    lat_fixed = 5;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      found = imem_req && mem_busy;
    end
    check("t7_in_wait", found, 1);
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("t7_rst_req", imem_req, 0);
    check("t7_rst_addr", imem_addr, RESET_PC);
    check("t7_rst_valid", instr_valid, 0);
    check("t7_rst_instr", instr, 0);
    check("t7_rst_pc", instr_pc, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t7_post_req", imem_req, 1);
    check("t7_post_addr", imem_addr, RESET_PC);
    check("t7_post_valid", instr_valid, 0);
    mem_busy = 1'b0;
    lat_fixed = 0;
    exp_pc = RESET_PC;
    tick();
    check("t7_entry_valid", instr_valid, 1);
    check("t7_entry_pc", instr_pc, RESET_PC);
    check("t7_entry_instr", instr, memf(RESET_PC));

    // Randomized latency, backpressure and redirects against the stream model
    lat_fixed = -1;
    lat_max = 3;
    key = $urandom;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      instr_ready = ($urandom_range(9, 0) < 7);
      redirect    = ($urandom_range(19, 0) == 0);
      redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                : ($urandom & 32'h0000_3FFF);
      tick();
    end
    redirect = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
